// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: MEM-side request/response, control strobes and the
// registered writeback bundle. The mem_error port exists only when
// MEM_WB_TIMEOUT_EN is defined.
interface mem_wb_stage_if;
    logic        valid_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        resp_b;
    logic        flush;
    logic [15:0] regfilemux_in;
    logic [2:0]  dest_in;
    logic        load_regfile_in;
    logic        br_en_in;
    logic [15:0] pc_in;

    logic        read_b;
    logic        write_b;
    logic        stall_mem;

    logic        wb_valid;
    logic [15:0] wb_data;
    logic [2:0]  wb_dest;
    logic        wb_load_regfile;
    logic        wb_br_en;
    logic [15:0] wb_pc;
    logic [15:0] stall_count;
`ifdef MEM_WB_TIMEOUT_EN
    logic        mem_error;
`endif

    // Upstream pipeline / memory side drives the stage
    modport master (
        output valid_in, mem_read_in, mem_write_in, resp_b, flush,
        output regfilemux_in, dest_in, load_regfile_in, br_en_in, pc_in,
        input  read_b, write_b, stall_mem,
        input  wb_valid, wb_data, wb_dest, wb_load_regfile, wb_br_en, wb_pc,
        input  stall_count
`ifdef MEM_WB_TIMEOUT_EN
        , input mem_error
`endif
    );

    // The stage itself
    modport slave (
        input  valid_in, mem_read_in, mem_write_in, resp_b, flush,
        input  regfilemux_in, dest_in, load_regfile_in, br_en_in, pc_in,
        output read_b, write_b, stall_mem,
        output wb_valid, wb_data, wb_dest, wb_load_regfile, wb_br_en, wb_pc,
        output stall_count
`ifdef MEM_WB_TIMEOUT_EN
        , output mem_error
`endif
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: gates data-memory strobes, stalls upstream while a
// memory access is outstanding and registers the writeback bundle.
// Optional feature: define MEM_WB_TIMEOUT_EN to bound WAIT with an 8-bit
// wait counter and a sticky mem_error output.
module mem_wb_stage (
    input  logic           clk,
    input  logic           reset,
    mem_wb_stage_if.slave  bus
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e      state_q, state_d;
    logic        req_rd_q, req_rd_d;
    logic        req_wr_q, req_wr_d;
    logic        killed_q, killed_d;
    logic        wb_valid_q, wb_valid_d;
    logic [15:0] wb_data_q, wb_data_d;
    logic [2:0]  wb_dest_q, wb_dest_d;
    logic        wb_lr_q, wb_lr_d;
    logic        wb_br_q, wb_br_d;
    logic [15:0] wb_pc_q, wb_pc_d;
    logic [15:0] stall_count_q, stall_count_d;

    logic mem_req, access;
    logic read_b, write_b, stall_mem, capture, timeout;

`ifdef MEM_WB_TIMEOUT_EN
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_error_q, mem_error_d;
`endif

    assign mem_req = bus.mem_read_in | bus.mem_write_in;
    assign access  = bus.valid_in & mem_req & ~bus.flush;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (access && !bus.resp_b) state_d = StWait;
            StWait: if (bus.resp_b || timeout) state_d = StIdle;
        endcase
    end

    // FSM outputs: strobes, stall and capture decision; all forced low in reset
    always_comb begin
        read_b    = 1'b0;
        write_b   = 1'b0;
        stall_mem = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        unique case (state_q)
            StIdle: begin
                read_b    = bus.mem_read_in & access;
                write_b   = bus.mem_write_in & access;
                stall_mem = access & ~bus.resp_b;
                // Non-memory ops and zero-wait accesses both capture here
                capture   = bus.valid_in & ~bus.flush & (~mem_req | bus.resp_b);
            end
            StWait: begin
                read_b    = req_rd_q;
                write_b   = req_wr_q;
`ifdef MEM_WB_TIMEOUT_EN
                timeout   = ~bus.resp_b & (wait_cnt_q == 8'hFF);
`endif
                stall_mem = ~bus.resp_b & ~timeout;
                // A flush seen at any point of the wait turns the capture into a bubble
                capture   = bus.resp_b & ~killed_q & ~bus.flush;
            end
        endcase
        if (reset) begin
            read_b    = 1'b0;
            write_b   = 1'b0;
            stall_mem = 1'b0;
            capture   = 1'b0;
            timeout   = 1'b0;
        end
    end

    // Datapath next-state: held request, kill flag, bundle, stall counter
    always_comb begin
        req_rd_d = req_rd_q;
        req_wr_d = req_wr_q;
        killed_d = killed_q;
        if (state_q == StIdle && state_d == StWait) begin
            req_rd_d = bus.mem_read_in;
            req_wr_d = bus.mem_write_in;
            killed_d = 1'b0;
        end else if (state_q == StWait) begin
            killed_d = (state_d == StWait) & (killed_q | bus.flush);
        end

        wb_valid_d = capture;
        wb_lr_d    = capture & bus.load_regfile_in;
        wb_br_d    = capture & bus.br_en_in;
        wb_data_d  = capture ? bus.regfilemux_in : wb_data_q;
        wb_dest_d  = capture ? bus.dest_in       : wb_dest_q;
        wb_pc_d    = capture ? bus.pc_in         : wb_pc_q;

        stall_count_d = stall_count_q;
        if (stall_mem && stall_count_q != 16'hFFFF) stall_count_d = stall_count_q + 16'd1;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            req_rd_q      <= 1'b0;
            req_wr_q      <= 1'b0;
            killed_q      <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_data_q     <= 16'h0000;
            wb_dest_q     <= 3'd0;
            wb_lr_q       <= 1'b0;
            wb_br_q       <= 1'b0;
            wb_pc_q       <= 16'h0000;
            stall_count_q <= 16'h0000;
        end else begin
            req_rd_q      <= req_rd_d;
            req_wr_q      <= req_wr_d;
            killed_q      <= killed_d;
            wb_valid_q    <= wb_valid_d;
            wb_data_q     <= wb_data_d;
            wb_dest_q     <= wb_dest_d;
            wb_lr_q       <= wb_lr_d;
            wb_br_q       <= wb_br_d;
            wb_pc_q       <= wb_pc_d;
            stall_count_q <= stall_count_d;
        end
    end

`ifdef MEM_WB_TIMEOUT_EN
    // Wait counter clears on WAIT entry and counts each WAIT cycle; error is sticky
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d == StWait) begin
            wait_cnt_d = (state_q == StIdle) ? 8'd0 : wait_cnt_q + 8'd1;
        end
        mem_error_d = mem_error_q | timeout;
    end

    // Timeout registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q  <= 8'd0;
            mem_error_q <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign bus.mem_error = mem_error_q;
`endif

    assign bus.read_b          = read_b;
    assign bus.write_b         = write_b;
    assign bus.stall_mem       = stall_mem;
    assign bus.wb_valid        = wb_valid_q;
    assign bus.wb_data         = wb_data_q;
    assign bus.wb_dest         = wb_dest_q;
    assign bus.wb_load_regfile = wb_lr_q;
    assign bus.wb_br_en        = wb_br_q;
    assign bus.wb_pc           = wb_pc_q;
    assign bus.stall_count     = stall_count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: transaction-level model plus
// directed scenarios with literal expectations.
module tb_mem_wb_stage;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    bit   cmp_en = 1'b0;

    mem_wb_stage_if bus ();

    mem_wb_stage dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef MEM_WB_TIMEOUT_EN
    localparam bit ToEn = 1'b1;
`else
    localparam bit ToEn = 1'b0;
`endif

    // Model: is an access outstanding, what was asked for, was it killed
    bit          m_busy = 0, m_rd = 0, m_wr = 0, m_killed = 0, m_err = 0;
    int          m_wait = 0;
    int          m_cnt  = 0;
    bit          m_wb_valid = 0, m_wb_lr = 0, m_wb_br = 0;
    logic [15:0] m_wb_data = '0, m_wb_pc = '0;
    logic [2:0]  m_wb_dest = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // What the stage must do this cycle given the model's view and the inputs
    task automatic model_now(output bit rd, output bit wr, output bit st, output bit cap,
                             output bit to);
        bit req = bus.mem_read_in | bus.mem_write_in;
        rd = 0; wr = 0; st = 0; cap = 0; to = 0;
        if (rst) return;
        if (!m_busy) begin
            bit go = bus.valid_in && req && !bus.flush;
            rd  = go && bus.mem_read_in;
            wr  = go && bus.mem_write_in;
            st  = go && !bus.resp_b;
            cap = bus.valid_in && !bus.flush && (!req || bus.resp_b);
        end else begin
            rd  = m_rd;
            wr  = m_wr;
            to  = ToEn && m_wait >= 255 && !bus.resp_b;
            st  = !bus.resp_b && !to;
            cap = bus.resp_b && !m_killed && !bus.flush;
        end
    endtask

    // Advance the model at each clock edge
    always @(posedge clk) begin
        bit rd, wr, st, cap, to;
        model_now(rd, wr, st, cap, to);
        if (rst) begin
            m_busy = 0; m_killed = 0; m_err = 0; m_wait = 0; m_cnt = 0;
            m_wb_valid = 0; m_wb_lr = 0; m_wb_br = 0;
            m_wb_data = '0; m_wb_pc = '0; m_wb_dest = '0;
        end else begin
            if (!m_busy) begin
                if (st) begin
                    m_busy = 1; m_rd = bus.mem_read_in; m_wr = bus.mem_write_in;
                    m_killed = 0; m_wait = 0;
                end
            end else begin
                if (bus.resp_b || to) m_busy = 0;
                else begin m_wait++; m_killed = m_killed || bus.flush; end
                if (to) m_err = 1;
            end
            if (st && m_cnt < 65535) m_cnt++;
            m_wb_valid = cap;
            m_wb_lr    = cap && bus.load_regfile_in;
            m_wb_br    = cap && bus.br_en_in;
            if (cap) begin
                m_wb_data = bus.regfilemux_in;
                m_wb_dest = bus.dest_in;
                m_wb_pc   = bus.pc_in;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        bit rd, wr, st, cap, to;
        if (cmp_en) begin
            model_now(rd, wr, st, cap, to);
            chk("read_b", bus.read_b, rd);
            chk("write_b", bus.write_b, wr);
            chk("stall_mem", bus.stall_mem, st);
            chk("wb_valid", bus.wb_valid, m_wb_valid);
            chk("wb_load_regfile", bus.wb_load_regfile, m_wb_lr);
            chk("wb_br_en", bus.wb_br_en, m_wb_br);
            chk("stall_count", bus.stall_count, m_cnt);
            if (m_wb_valid) begin
                chk("wb_data", bus.wb_data, m_wb_data);
                chk("wb_dest", bus.wb_dest, m_wb_dest);
                chk("wb_pc", bus.wb_pc, m_wb_pc);
            end
`ifdef MEM_WB_TIMEOUT_EN
            chk("mem_error", bus.mem_error, m_err);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.valid_in = 0; bus.mem_read_in = 0; bus.mem_write_in = 0;
        bus.resp_b = 0; bus.flush = 0;
        bus.regfilemux_in = '0; bus.dest_in = '0; bus.load_regfile_in = 0;
        bus.br_en_in = 0; bus.pc_in = '0;
    endtask

    initial begin
        bit all_st;
        rst = 1;
        idle_in();
        cyc();
        cmp_en = 1;
        // Reset state and gated outputs during reset
        chk("rst_wb_valid", bus.wb_valid, 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_wb_pc", bus.wb_pc, 0);
        chk("rst_stall_count", bus.stall_count, 0);
        bus.valid_in = 1; bus.mem_read_in = 1;
        #2;
        chk("rst_read_b", bus.read_b, 0);
        chk("rst_stall_mem", bus.stall_mem, 0);
        cyc();
        rst = 0;

        // Zero-wait load
        bus.valid_in = 1; bus.mem_read_in = 1; bus.resp_b = 1;
        bus.regfilemux_in = 16'h1234; bus.dest_in = 3; bus.load_regfile_in = 1;
        #2;
        chk("zw_stall", bus.stall_mem, 0);
        chk("zw_read_b", bus.read_b, 1);
        cyc(); idle_in();
        chk("zw_wb_valid", bus.wb_valid, 1);
        chk("zw_wb_data", bus.wb_data, 16'h1234);
        chk("zw_wb_dest", bus.wb_dest, 3);
        cyc();

        // Three-cycle store
        bus.valid_in = 1; bus.mem_write_in = 1; bus.regfilemux_in = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            bus.resp_b = (i == 2);
            #2;
            chk("st_stall", bus.stall_mem, (i < 2));
            chk("st_write_b", bus.write_b, 1);
            chk("st_no_wb", bus.wb_valid, 0);
            cyc();
        end
        idle_in();
        chk("st_wb_valid", bus.wb_valid, 1);
        chk("st_count", bus.stall_count, 2);
        cyc();
        chk("st_one_pulse", bus.wb_valid, 0);

        // ALU op, no memory access
        bus.valid_in = 1; bus.pc_in = 16'h0040; bus.br_en_in = 1; bus.regfilemux_in = 16'h00AA;
        #2;
        chk("alu_stall", bus.stall_mem, 0);
        cyc(); idle_in();
        chk("alu_wb_valid", bus.wb_valid, 1);
        chk("alu_wb_pc", bus.wb_pc, 16'h0040);
        chk("alu_wb_br", bus.wb_br_en, 1);

        // Stray response ignored; flush in IDLE suppresses strobes
        bus.resp_b = 1;
        cyc();
        bus.resp_b = 0; bus.valid_in = 1; bus.mem_read_in = 1; bus.flush = 1;
        #2;
        chk("fl_read_b", bus.read_b, 0);
        chk("fl_stall", bus.stall_mem, 0);
        cyc(); idle_in();
        chk("fl_bubble", bus.wb_valid, 0);

        // Flush while waiting
        bus.valid_in = 1; bus.mem_read_in = 1;
        cyc();
        bus.flush = 1;
        #2;
        chk("fw_stall", bus.stall_mem, 1);
        chk("fw_read_b", bus.read_b, 1);
        cyc();
        bus.flush = 0; bus.resp_b = 1;
        #2;
        chk("fw_release", bus.stall_mem, 0);
        cyc();
        chk("fw_no_wb", bus.wb_valid, 0);
        chk("fw_count", bus.stall_count, 4);
        bus.regfilemux_in = 16'hBEEF;
        #2;
        chk("fw_next_zw", bus.stall_mem, 0);
        cyc(); idle_in();
        chk("fw_next_wb", bus.wb_valid, 1);

        // Reset while waiting, then a stray response
        bus.valid_in = 1; bus.mem_read_in = 1;
        cyc();
        rst = 1;
        #2;
        chk("rw_stall", bus.stall_mem, 0);
        chk("rw_read_b", bus.read_b, 0);
        cyc();
        rst = 0; idle_in(); bus.resp_b = 1;
        #2;
        chk("rw_stray_stall", bus.stall_mem, 0);
        chk("rw_stray_read", bus.read_b, 0);
        cyc(); idle_in();
        chk("rw_wb_valid", bus.wb_valid, 0);
        chk("rw_wb_data", bus.wb_data, 0);
        chk("rw_count", bus.stall_count, 0);

`ifdef MEM_WB_TIMEOUT_EN
        // Timeout after 255 WAIT cycles
        bus.valid_in = 1; bus.mem_read_in = 1;
        cyc();
        all_st = 1;
        for (int i = 0; i < 255; i++) begin
            #2;
            if (bus.stall_mem !== 1'b1) all_st = 0;
            cyc();
        end
        chk("to_stalled", all_st, 1);
        #2;
        chk("to_release", bus.stall_mem, 0);
        cyc(); idle_in();
        chk("to_error", bus.mem_error, 1);
        chk("to_bubble", bus.wb_valid, 0);
        cyc();
        chk("to_sticky", bus.mem_error, 1);
        rst = 1;
        cyc();
        rst = 0;
`endif

        // Saturation of the stall counter
        bus.valid_in = 1; bus.mem_read_in = 1;
        repeat (65800) cyc();
        chk("sat_count", bus.stall_count, 16'hFFFF);
        cyc();
        chk("sat_hold", bus.stall_count, 16'hFFFF);
        bus.resp_b = 1;
        cyc(); idle_in();
        cyc();

        cmp_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset. One clock only.
REQ-002 SHALL have ports: valid_in  in  1  MEM-stage instruction valid; mem_read_in  in  1  load request; mem_write_in  in  1  store request.
REQ-003 SHALL have ports: resp_b  in  1  data-memory response; flush  in  1  kill the MEM-stage instruction.
REQ-004 SHALL have ports: regfilemux_in  in  16  writeback value; dest_in  in  3  destination register; load_regfile_in  in  1  writes register file; br_en_in  in  1  branch taken; pc_in  in  16  instruction PC.
REQ-005 SHALL have ports: read_b  out  1  gated load strobe; write_b  out  1  gated store strobe; stall_mem  out  1  freeze upstream stages.
REQ-006 SHALL have ports: wb_valid  out  1; wb_data  out  16; wb_dest  out  3; wb_load_regfile  out  1; wb_br_en  out  1; wb_pc  out  16. Together these form the registered MEM/WB bundle.
REQ-007 SHALL have port stall_count  out  16  saturating count of stalled cycles.

Function
REQ-008 An access SHALL be active when valid_in & (mem_read_in | mem_write_in) & ~flush.
REQ-009 The FSM SHALL have two states: IDLE and WAIT.
REQ-010 In IDLE, read_b and write_b SHALL equal mem_read_in and mem_write_in, each gated by access-active. In WAIT, both SHALL be held from the request.
REQ-011 In IDLE with access active and resp_b=0: stall_mem=1 combinationally, and next state is WAIT.
REQ-012 In IDLE with access active and resp_b=1 (zero-wait): stall_mem=0, the bundle captures at this edge, and the FSM stays in IDLE.
REQ-013 In WAIT: stall_mem = ~resp_b. On resp_b=1, the bundle captures and the FSM returns to IDLE in the same edge.
REQ-014 In IDLE with valid_in=1 and no memory access: stall_mem=0, and the bundle captures with latency 1.
REQ-015 Capture SHALL set wb_valid=1 and load wb_data, wb_dest, wb_load_regfile, wb_br_en and wb_pc from the inputs.
REQ-016 When no capture occurs and stall_mem=0, the next edge SHALL load a bubble: wb_valid=0, wb_load_regfile=0, wb_br_en=0, other fields don't-care.
REQ-017 While stall_mem=1, the bundle SHALL load a bubble each cycle; the same instruction SHALL never be written back twice.
REQ-018 flush in IDLE SHALL suppress read_b and write_b, and the bundle SHALL load a bubble.
REQ-019 flush in WAIT SHALL NOT abort the access. The response SHALL be awaited; on resp_b the bundle loads a bubble instead of a capture.
REQ-020 stall_count SHALL increment by 1 on each edge with stall_mem=1 and saturate at 16'hFFFF with no wrap.
REQ-021 resp_b in IDLE with no access active SHALL be ignored.

Reset
REQ-022 On reset=1 at a clock edge: state=IDLE, wb_valid=0, wb_data=0, wb_dest=0, wb_load_regfile=0, wb_br_en=0, wb_pc=0, stall_count=0.
REQ-023 During reset, read_b, write_b and stall_mem SHALL be 0.
REQ-024 Reset asserted in WAIT SHALL abandon the access; a later stray resp_b SHALL be ignored per REQ-021.

Configuration
REQ-025 Macro MEM_WB_TIMEOUT_EN SHALL compile in an 8-bit wait counter and output mem_error (out 1, sticky, reset 0).
REQ-026 With MEM_WB_TIMEOUT_EN, the counter SHALL clear on entry to WAIT and increment each WAIT cycle. On reaching 255 without resp_b: mem_error=1, the FSM goes to IDLE, stall_mem=0, and the bundle loads a bubble.
REQ-027 Without MEM_WB_TIMEOUT_EN, the mem_error port and the counter SHALL be absent, and WAIT is unbounded.

Verification
REQ-028 Zero-wait load: valid_in=1, mem_read_in=1, resp_b=1, regfilemux_in=16'h1234, dest_in=3 -> stall_mem=0 and read_b=1. Next cycle: wb_valid=1, wb_data=16'h1234, wb_dest=3.
REQ-029 3-cycle store: mem_write_in=1, resp_b low 2 cycles then high -> stall_mem=1,1,0, write_b=1 throughout, stall_count=2, exactly one wb_valid pulse.
REQ-030 ALU op with no memory access and pc_in=16'h0040 -> next cycle wb_valid=1, wb_pc=16'h0040, stall_mem never 1.
REQ-031 flush in WAIT, then resp_b=1 -> stall releases that cycle, wb_valid stays 0, and next access starts from IDLE.
REQ-032 reset in WAIT, then resp_b=1 -> all outputs 0 and no capture. Saturation: force 65536+ stall cycles -> stall_count holds 16'hFFFF.
REQ-033 With MEM_WB_TIMEOUT_EN: resp_b held 0 for 255 WAIT cycles -> mem_error=1 and stays 1, stall_mem=0, wb_valid=0.
